// File: rtl/cpu_defs.sv
// Shared CPU definitions: FSM state encodings, control-field codes, instruction constants
// and the controller's state/instruction-class to control-word decode.
package cpu_defs;

    localparam int unsigned STATE_W  = 5;
    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned NSEL_W   = 3;
    localparam int unsigned VSEL_W   = 2;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned MEMCMD_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_RST   = 5'd0,
        S_IF1   = 5'd1,
        S_IF2   = 5'd2,
        S_UPC   = 5'd3,
        S_DEC   = 5'd4,
        S_IMM   = 5'd5,
        S_GETA  = 5'd6,
        S_GETB  = 5'd7,
        S_ALU   = 5'd8,
        S_WRC   = 5'd9,
        S_ADDR  = 5'd10,
        S_LADDR = 5'd11,
        S_MRD   = 5'd12,
        S_WRM   = 5'd13,
        S_GETD  = 5'd14,
        S_PASS  = 5'd15,
        S_MWR   = 5'd16,
        S_HALT  = 5'd17
    } state_e;

    localparam logic [MEMCMD_W-1:0] MEM_NONE = 2'b00;
    localparam logic [MEMCMD_W-1:0] MEM_RD   = 2'b01;
    localparam logic [MEMCMD_W-1:0] MEM_WR   = 2'b10;

    localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
    localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b100;
    localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
    localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b001;

    localparam logic [VSEL_W-1:0] VSEL_C      = 2'b00;
    localparam logic [VSEL_W-1:0] VSEL_PC     = 2'b01;
    localparam logic [VSEL_W-1:0] VSEL_SXIMM8 = 2'b10;
    localparam logic [VSEL_W-1:0] VSEL_MDATA  = 2'b11;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_NOTB = 2'b11;

    localparam logic [OPCODE_W-1:0] OPC_LDR  = 3'b011;
    localparam logic [OPCODE_W-1:0] OPC_STR  = 3'b100;
    localparam logic [OPCODE_W-1:0] OPC_ALU  = 3'b101;
    localparam logic [OPCODE_W-1:0] OPC_MOV  = 3'b110;
    localparam logic [OPCODE_W-1:0] OPC_HALT = 3'b111;

    localparam logic [OP_W-1:0] OP_MOV_SH  = 2'b00;
    localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
    localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
    localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
    localparam logic [OP_W-1:0] OP_AND     = 2'b10;
    localparam logic [OP_W-1:0] OP_MVN     = 2'b11;
    localparam logic [OP_W-1:0] OP_MEM     = 2'b00;

    // Instruction class, resolved once in S_DEC and held for the rest of the instruction
    typedef enum logic [3:0] {
        K_NONE  = 4'd0,
        K_MOVI  = 4'd1,
        K_MOVSH = 4'd2,
        K_MVN   = 4'd3,
        K_ADD   = 4'd4,
        K_CMP   = 4'd5,
        K_AND   = 4'd6,
        K_LDR   = 4'd7,
        K_STR   = 4'd8,
        K_HALT  = 4'd9
    } kind_e;

    typedef struct packed {
        logic [NSEL_W-1:0]   nsel;
        logic [VSEL_W-1:0]   vsel;
        logic [ALUOP_W-1:0]  alu_op;
        logic                shift_en;
        logic                asel;
        logic                bsel;
        logic                loada;
        logic                loadb;
        logic                loadc;
        logic                loads;
        logic                write;
        logic                load_ir;
        logic                load_pc;
        logic                reset_pc;
        logic                addr_sel;
        logic                load_addr;
        logic [MEMCMD_W-1:0] mem_cmd;
        logic                halted;
    } ctrl_t;

    function automatic kind_e classify(input logic [OPCODE_W-1:0] opcode,
                                       input logic [OP_W-1:0]     op);
        kind_e k;
        k = K_NONE;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)     k = K_MOVI;
                else if (op == OP_MOV_SH) k = K_MOVSH;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD:  k = K_ADD;
                    OP_CMP:  k = K_CMP;
                    OP_AND:  k = K_AND;
                    default: k = K_MVN;
                endcase
            end
            OPC_LDR:  if (op == OP_MEM) k = K_LDR;
            OPC_STR:  if (op == OP_MEM) k = K_STR;
            OPC_HALT: k = K_HALT;
            default:  k = K_NONE;
        endcase
        return k;
    endfunction

    function automatic logic [ALUOP_W-1:0] alu_of(input kind_e k);
        logic [ALUOP_W-1:0] a;
        case (k)
            K_CMP:   a = ALU_SUB;
            K_AND:   a = ALU_AND;
            K_MVN:   a = ALU_NOTB;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Moore control word for a state; the class only refines S_ALU
    function automatic ctrl_t ctrl_of(input state_e s, input kind_e k);
        ctrl_t c;
        c         = '0;
        c.nsel    = NSEL_NONE;
        c.vsel    = VSEL_C;
        c.alu_op  = ALU_ADD;
        c.mem_cmd = MEM_NONE;
        case (s)
            S_RST: begin
                c.reset_pc = 1'b1;
                c.load_pc  = 1'b1;
            end
            S_IF1: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_RD;
            end
            S_IF2: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_RD;
                c.load_ir  = 1'b1;
            end
            S_UPC:  c.load_pc = 1'b1;
            S_IMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_SXIMM8;
                c.write = 1'b1;
            end
            S_GETA: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_GETB: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_ALU: begin
                c.shift_en = 1'b1;
                c.asel     = (k == K_MOVSH);
                c.alu_op   = alu_of(k);
                c.loadc    = (k != K_CMP);
                c.loads    = (k == K_CMP);
            end
            S_WRC: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            S_ADDR: begin
                c.bsel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_LADDR: c.load_addr = 1'b1;
            S_MRD:   c.mem_cmd   = MEM_RD;
            S_WRM: begin
                c.mem_cmd = MEM_RD;
                c.nsel    = NSEL_RD;
                c.vsel    = VSEL_MDATA;
                c.write   = 1'b1;
            end
            S_GETD: begin
                c.nsel  = NSEL_RD;
                c.loadb = 1'b1;
            end
            S_PASS: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_MWR:  c.mem_cmd = MEM_WR;
            S_HALT: c.halted  = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Controller <-> datapath/decoder bundle: decoded opcode fields in, control strobes out.
interface cpu_control_fsm_if;
    import cpu_defs::*;

    logic [OPCODE_W-1:0] opcode;
    logic [OP_W-1:0]     op;
    logic [NSEL_W-1:0]   nsel;
    logic [VSEL_W-1:0]   vsel;
    logic [ALUOP_W-1:0]  alu_op;
    logic                shift_en;
    logic                asel;
    logic                bsel;
    logic                loada;
    logic                loadb;
    logic                loadc;
    logic                loads;
    logic                write;
    logic                load_ir;
    logic                load_pc;
    logic                reset_pc;
    logic                addr_sel;
    logic                load_addr;
    logic [MEMCMD_W-1:0] mem_cmd;
    logic                halted;

    modport master (
        input  opcode, op,
        output nsel, vsel, alu_op, shift_en, asel, bsel, loada, loadb, loadc, loads,
               write, load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
    );

    modport slave (
        output opcode, op,
        input  nsel, vsel, alu_op, shift_en, asel, bsel, loada, loadb, loadc, loads,
               write, load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
    );

endinterface

// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit CPU; one instruction in flight.
// The control word is registered from the next state, so it always matches state_q.
module cpu_control_fsm
    import cpu_defs::*;
#(
    parameter bit ILLEGAL_HALTS = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    cpu_control_fsm_if.master   ctl
);

    state_e state_q, state_d;
    kind_e  kind_q,  kind_d;
    ctrl_t  ctrl_q,  ctrl_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            kind_q  <= K_NONE;
            ctrl_q  <= ctrl_of(S_RST, K_NONE);
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        case (state_q)
            S_RST:  state_d = S_IF1;
            S_IF1:  state_d = S_IF2;
            S_IF2:  state_d = S_UPC;
            S_UPC:  state_d = S_DEC;
            S_DEC: begin
                kind_d = classify(ctl.opcode, ctl.op);
                case (kind_d)
                    K_MOVI:                              state_d = S_IMM;
                    K_MOVSH, K_MVN:                      state_d = S_GETB;
                    K_ADD, K_CMP, K_AND, K_LDR, K_STR:   state_d = S_GETA;
                    K_HALT:                              state_d = S_HALT;
                    default: state_d = ILLEGAL_HALTS ? S_HALT : S_IF1;
                endcase
            end
            S_IMM:   state_d = S_IF1;
            S_GETA:  state_d = (kind_q == K_LDR || kind_q == K_STR) ? S_ADDR : S_GETB;
            S_GETB:  state_d = S_ALU;
            S_ALU:   state_d = (kind_q == K_CMP) ? S_IF1 : S_WRC;
            S_WRC:   state_d = S_IF1;
            S_ADDR:  state_d = S_LADDR;
            S_LADDR: state_d = (kind_q == K_LDR) ? S_MRD : S_GETD;
            S_MRD:   state_d = S_WRM;
            S_WRM:   state_d = S_IF1;
            S_GETD:  state_d = S_PASS;
            S_PASS:  state_d = S_MWR;
            S_MWR:   state_d = S_IF1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
        ctrl_d = ctrl_of(state_d, kind_d);
    end

    assign ctl.nsel      = ctrl_q.nsel;
    assign ctl.vsel      = ctrl_q.vsel;
    assign ctl.alu_op    = ctrl_q.alu_op;
    assign ctl.shift_en  = ctrl_q.shift_en;
    assign ctl.asel      = ctrl_q.asel;
    assign ctl.bsel      = ctrl_q.bsel;
    assign ctl.loada     = ctrl_q.loada;
    assign ctl.loadb     = ctrl_q.loadb;
    assign ctl.loadc     = ctrl_q.loadc;
    assign ctl.loads     = ctrl_q.loads;
    assign ctl.write     = ctrl_q.write;
    assign ctl.load_ir   = ctrl_q.load_ir;
    assign ctl.load_pc   = ctrl_q.load_pc;
    assign ctl.reset_pc  = ctrl_q.reset_pc;
    assign ctl.addr_sel  = ctrl_q.addr_sel;
    assign ctl.load_addr = ctrl_q.load_addr;
    assign ctl.mem_cmd   = ctrl_q.mem_cmd;
    assign ctl.halted    = ctrl_q.halted;

endmodule
